// File: rtl/serial_subtractor_4bit_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding,
// default operand width and bit-counter sizing.
package serial_subtractor_4bit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;
    localparam int CNT_W         = $clog2(DEFAULT_WIDTH);

    // Counter width for an arbitrary operand width; never narrower than 1 bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_4bit_sub.sv
// full_subtractor_1bit: combinational 1-bit full subtractor, the mirror of
// the adder's 1-bit cell. Computes a - b - borrow_in.
module full_subtractor_1bit (
    input  logic a,
    input  logic b,
    input  logic borrow_in,
    output logic diff,
    output logic borrow_out
);

    // Difference bit and borrow generation for one bit position.
    always_comb begin
        diff       = a ^ b ^ borrow_in;
        borrow_out = (~a & b) | (~(a ^ b) & borrow_in);
    end

endmodule

// File: rtl/serial_subtractor_4bit.sv
// serial_subtractor_4bit: bit-serial diff = A - B - borrow_in, one bit per
// clock, LSB first, through a single full-subtractor cell and a borrow flop.
//
// Handshake: start is sampled only in IDLE; on acceptance A, B and borrow_in
// are captured and may change afterwards. busy is high for the WIDTH shift
// cycles, then done pulses for one cycle with diff/borrow_out valid. diff and
// borrow_out hold until the next result is written. start in SHIFT or DONE is
// dropped, not queued.
//
// Optional feature: define SUB_SIGNED_OVF_EN to add the signed overflow
// output and the captured operand-MSB flops it needs.
module serial_subtractor_4bit
    import serial_subtractor_4bit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SUB_SIGNED_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int CW = cnt_width(WIDTH);

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] shift_a;
    logic [WIDTH-1:0] shift_b;
    logic [WIDTH-2:0] res_sr;   // lower result bits collected so far
    logic             brw;
    logic [CW-1:0]    bit_cnt;
    logic             last_bit;
    logic             fs_diff;
    logic             fs_bout;
`ifdef SUB_SIGNED_OVF_EN
    logic             a_msb;
    logic             b_msb;
`endif

    assign last_bit = (bit_cnt == CW'(WIDTH - 1));

    full_subtractor_1bit u_fs (
        .a          (shift_a[0]),
        .b          (shift_b[0]),
        .borrow_in  (brw),
        .diff       (fs_diff),
        .borrow_out (fs_bout)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state logic: IDLE -> SHIFT on start, SHIFT -> DONE after the last bit.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)    state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:                  state_next = IDLE;
            default:               state_next = IDLE;
        endcase
    end

    // Status outputs decoded from state; busy and done are mutually exclusive.
    always_comb begin
        busy = (state == SHIFT);
        done = (state == DONE);
    end

    // Operand capture, serial shifting and result/borrow registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shift_a    <= '0;
            shift_b    <= '0;
            res_sr     <= '0;
            brw        <= 1'b0;
            bit_cnt    <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            overflow   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_a <= A;
                        shift_b <= B;
                        brw     <= borrow_in;
                        bit_cnt <= '0;
`ifdef SUB_SIGNED_OVF_EN
                        a_msb   <= A[WIDTH-1];
                        b_msb   <= B[WIDTH-1];
`endif
                    end
                end
                SHIFT: begin
                    shift_a <= {1'b0, shift_a[WIDTH-1:1]};
                    shift_b <= {1'b0, shift_b[WIDTH-1:1]};
                    res_sr  <= {fs_diff, res_sr[WIDTH-2:1]};
                    brw     <= fs_bout;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (last_bit) begin
                        diff       <= {fs_diff, res_sr};
                        borrow_out <= fs_bout;
`ifdef SUB_SIGNED_OVF_EN
                        overflow   <= (a_msb != b_msb) && (fs_diff != a_msb);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor_4bit.sv
// Bench for serial_subtractor_4bit: table of vectors applied through a
// start/done handshake with a scoreboard queue, plus hand-written sequences
// for dropped starts and reset during an operation.
// Build with +define+SUB_SIGNED_OVF_EN to also check the overflow output.
module tb_serial_subtractor_4bit;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] exp_diff;
        logic         exp_bout;
        logic         exp_ovf;
    } vec_t;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         borrow_in;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         ovf_act;
`ifdef SUB_SIGNED_OVF_EN
    logic         overflow;
    assign ovf_act = overflow;
`else
    assign ovf_act = 1'b0;
`endif

    // Scoreboard entries are {overflow, borrow_out, diff}.
    logic [W+1:0] exp_q[$];
    int n_vec    = 0;
    int n_err    = 0;
    int done_cnt = 0;

    serial_subtractor_4bit #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .A          (A),
        .B          (B),
        .borrow_in  (borrow_in),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef SUB_SIGNED_OVF_EN
        ,
        .overflow   (overflow)
`endif
    );

    // Clock and global watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Arithmetic reference: modulo subtraction, unsigned borrow, signed overflow.
    function automatic vec_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        vec_t v;
        int   d;
        v.a        = a;
        v.b        = b;
        v.bin      = bin;
        d          = int'(a) - int'(b) - int'(bin);
        v.exp_diff = W'(d);
        v.exp_bout = (d < 0);
        v.exp_ovf  = (a[W-1] != b[W-1]) && (v.exp_diff[W-1] != a[W-1]);
        return v;
    endfunction

    function automatic logic [W+1:0] pack_exp(input vec_t v);
`ifdef SUB_SIGNED_OVF_EN
        return {v.exp_ovf, v.exp_bout, v.exp_diff};
`else
        return {1'b0, v.exp_bout, v.exp_diff};
`endif
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (reset_n && done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got diff=%0d with no pending expectation", diff);
            end else begin
                logic [W+1:0] e;
                e = exp_q.pop_front();
                check("result_diff", 32'(diff), 32'(e[W-1:0]));
                check("result_borrow", 32'(borrow_out), 32'(e[W]));
                check("result_overflow", 32'(ovf_act), 32'(e[W+1]));
            end
        end
    end

    // Drive one start pulse from a negedge; returns at the negedge of cycle E0+1.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                         input bit push, input logic [W+1:0] e);
        A         = a;
        B         = b;
        borrow_in = bin;
        start     = 1'b1;
        if (push) exp_q.push_back(e);
        @(negedge clk);
        start     = 1'b0;
        A         = W'($urandom_range(0, (1 << W) - 1));
        B         = W'($urandom_range(0, (1 << W) - 1));
        borrow_in = 1'($urandom_range(0, 1));
    endtask

    // Sample once per cycle until done (bounded); lat counts from the current cycle as 1.
    task automatic wait_done(output int lat, output int bcnt, output int both);
        lat  = 0;
        bcnt = 0;
        both = 0;
        for (int k = 1; k <= 20; k++) begin
            if (busy && done) both = 1;
            if (busy) bcnt++;
            if (done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_op(input vec_t v);
        int lat, bcnt, both;
        issue(v.a, v.b, v.bin, 1'b1, pack_exp(v));
        wait_done(lat, bcnt, both);
        check("done_latency", 32'(lat), 32'd5);
        check("busy_cycles", 32'(bcnt), 32'd4);
        check("busy_done_overlap", 32'(both), 32'd0);
        @(negedge clk);
    endtask

    vec_t vecs[12];

    initial begin
        int lat, bcnt, both;
        int dc0;

        // Hand-derived vectors first, then model-computed random ones.
        vecs[0] = '{4'd9,  4'd5,  1'b0, 4'd4,  1'b0, 1'b1};
        vecs[1] = '{4'd3,  4'd5,  1'b0, 4'd14, 1'b1, 1'b0};
        vecs[2] = '{4'd0,  4'd0,  1'b1, 4'd15, 1'b1, 1'b0};
        vecs[3] = '{4'd15, 4'd15, 1'b0, 4'd0,  1'b0, 1'b0};
        vecs[4] = '{4'd8,  4'd1,  1'b0, 4'd7,  1'b0, 1'b1};
        vecs[5] = '{4'd6,  4'd2,  1'b0, 4'd4,  1'b0, 1'b0};
        for (int i = 6; i < 12; i++)
            vecs[i] = model(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)),
                            1'($urandom_range(0, 1)));

        // Reset block.
        reset_n   = 1'b0;
        start     = 1'b0;
        A         = '0;
        B         = '0;
        borrow_in = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_diff", 32'(diff), 32'd0);
        check("reset_borrow", 32'(borrow_out), 32'd0);
        check("reset_overflow", 32'(ovf_act), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Table-driven vectors.
        for (int i = 0; i < 12; i++) run_op(vecs[i]);

        // Start pulses during busy and during done are dropped.
        dc0 = done_cnt;
        issue(4'd7, 4'd2, 1'b0, 1'b1, pack_exp(model(4'd7, 4'd2, 1'b0)));
        @(negedge clk);
        A = 4'd1; B = 4'd1; borrow_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bcnt, both);
        check("busy_start_latency", 32'(lat), 32'd3);
        A = 4'd1; B = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("done_start_busy", 32'(busy), 32'd0);
        repeat (10) @(negedge clk);
        check("dropped_start_dones", 32'(done_cnt - dc0), 32'd1);
        check("dropped_start_diff", 32'(diff), 32'd5);

        // Reset on the second busy cycle aborts without a done pulse.
        dc0 = done_cnt;
        issue(4'd12, 4'd4, 1'b0, 1'b0, '0);
        @(negedge clk);
        check("abort_busy_before", 32'(busy), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_diff", 32'(diff), 32'd0);
        check("abort_borrow", 32'(borrow_out), 32'd0);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - dc0), 32'd0);
        run_op(model(4'd12, 4'd4, 1'b0));

        // Back-to-back issue at the maximum rate.
        run_op(model(4'd10, 4'd3, 1'b1));
        run_op(model(4'd1, 4'd14, 1'b1));

        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_subtractor_4bit.md
# serial_subtractor_4bit

Sequential bit-serial 4-bit subtractor, the inverse datapath of the 4-bit ripple-carry adder. It computes diff = A − B − borrow_in one bit per clock through a single 1-bit full subtractor and a borrow flop. It uses a start/busy/done handshake, so a controller can issue subtractions without a combinational ripple path. It sits beside the adder in the ALU datapath.

## Interface
Parameters:
- WIDTH, 4, operand and result width in bits; the test plan targets 4.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset_n  input  1  reset is synchronous and active-low.
- start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  minuend, captured when start is accepted.
- B  input  WIDTH  subtrahend, captured when start is accepted.
- borrow_in  input  1  initial borrow, captured with A/B.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when the result is valid.
- diff  output  WIDTH  result; held until the next accepted start.
- borrow_out  output  1  final borrow; held with diff.
- overflow  output  1  signed overflow; exists only with SUB_SIGNED_OVF_EN.

## Operation
- FSM states are IDLE, SHIFT and DONE. The reset state is IDLE.
- IDLE: if start = 1 at a clock edge:
  - load shift_a ← A, shift_b ← B, borrow ← borrow_in;
  - clear bit_cnt;
  - go to SHIFT.
- SHIFT: each cycle applies the full subtractor to shift_a[0], shift_b[0] and borrow:
  - d = a ^ b ^ bin;
  - bout = (~a & b) | (~(a ^ b) & bin);
  - d shifts into the MSB of the result register (LSB first);
  - shift_a and shift_b shift right by 1; borrow ← bout; bit_cnt increments.
- After WIDTH SHIFT cycles (bit_cnt = WIDTH−1 processed), go to DONE.
  - The diff and borrow_out registers update at that edge.
- DONE: done = 1 for exactly one cycle, then go to IDLE.
- start is ignored in SHIFT and DONE. There is no queueing; a dropped request must be reissued.
- A, B and borrow_in may change freely after acceptance.
- Arithmetic is modulo 2^WIDTH. borrow_out = 1 exactly when A < B + borrow_in (unsigned).
- Reset values: busy = 0, done = 0, diff = 0, borrow_out = 0, overflow = 0. The FSM is in IDLE.
- Reset asserted mid-operation: the next edge returns to IDLE with all outputs cleared. No done pulse is produced for the aborted operation.

## Timing
- Edge E0: start accepted.
- busy is high during cycles E0+1 … E0+WIDTH, which is 4 cycles for WIDTH = 4.
- done is high in cycle E0+WIDTH+1. diff and borrow_out are valid from that cycle and stay stable until the next result.
- Earliest next acceptance: start high during the done cycle is ignored. Start is accepted at the first edge after the FSM returns to IDLE.
- Issue rate: one operation per WIDTH+2 cycles.
- busy and done are never high in the same cycle.

## Configuration
- SUB_SIGNED_OVF_EN defined:
  - the overflow port and its register are present;
  - overflow = (A[MSB] ≠ B[MSB]) & (diff[MSB] ≠ A[MSB]), using captured operand MSBs;
  - it updates with diff.
- SUB_SIGNED_OVF_EN not defined:
  - the port, the register and the captured-MSB flops are absent;
  - all other behaviour is identical.

## Structure
- Shared package holds:
  - FSM state typedef (IDLE, SHIFT, DONE);
  - the default WIDTH constant;
  - the bit counter width constant, $clog2(WIDTH).
- One sub-module, full_subtractor_1bit, is purely combinational: inputs a, b, borrow_in; outputs diff, borrow_out. It is the mirror of the adder's 1-bit cell.
- The top level holds the FSM, shift registers, result register and borrow flop.

## Test plan
- A=9, B=5, borrow_in=0, pulse start → done after 5 cycles; diff=4, borrow_out=0; busy high for exactly 4 cycles.
- A=3, B=5, borrow_in=0 → diff=14 (0xE), borrow_out=1.
- A=0, B=0, borrow_in=1 → diff=15, borrow_out=1. A=15, B=15, borrow_in=0 → diff=0, borrow_out=0.
- Start A=7,B=2 then pulse start with A=1,B=1 during busy → only one done, diff=5; start during the done cycle is also ignored.
- Start A=12,B=4, deassert reset_n on the 2nd busy cycle → next cycle busy=0, diff=0, no done pulse; a subsequent start works normally.
- With SUB_SIGNED_OVF_EN: A=8 (−8), B=1 → diff=7, overflow=1. A=6, B=2 → diff=4, overflow=0.
